aes_inv_key_sched: RTL and testbench

Iterative AES-128 decryption key scheduler. It accepts a 128-bit cipher key, expands it forward to the round-10 key, then streams round keys in reverse order (10 down to 0) over a valid/ready interface. The decryption datapath consumes this stream in its AddRoundKey stage. AddRoundKey is its own inverse, so that stage needs only the round keys in the order produced here.

---
 rtl/aes_pkg.sv | 46 ++++
 rtl/aes_sbox.sv | 11 +
 rtl/aes_inv_key_sched.sv | 109 ++++++++++
 tb/tb_aes_inv_key_sched.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and types: S-box table, round constants, key-scheduler state/round types.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    STREAM = 2'd2
  } state_t;

  typedef logic [3:0] rnd_t;

  localparam rnd_t LAST_ROUND = 4'd10;

  // Index 0 is unused; rounds 1..10 map directly onto the table.
  localparam logic [0:10][7:0] RCON = {
    8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Out-of-range rounds yield zero so a stray counter value cannot index past the table.
  function automatic logic [7:0] rcon_byte(input rnd_t r);
    if (r >= 4'd1 && r <= LAST_ROUND) begin
      return RCON[r];
    end
    return 8'h00;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box lookup, one byte in, one byte out.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] addr,
  output logic [7:0] data
);

  assign data = SBOX[addr];

endmodule

// File: rtl/aes_inv_key_sched.sv
// AES-128 key scheduler for decryption: expands forward to round 10, then
// streams round keys 10..0 by running the schedule backwards one step per handshake.
module aes_inv_key_sched
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_last,
  output logic         busy
);

  state_t       state_reg, state_next;
  logic [127:0] key_reg, key_next;
  rnd_t         cnt_reg, cnt_next;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] sub_in, rot_word, sub_word, t_word;

  assign {w0, w1, w2, w3} = key_reg;

  // Backward step needs SubWord of the previous round's w3, which is w3 ^ w2.
  assign sub_in   = (state_reg == STREAM) ? (w3 ^ w2) : w3;
  assign rot_word = {sub_in[23:0], sub_in[31:24]};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .addr (rot_word[gi*8 +: 8]),
        .data (sub_word[gi*8 +: 8])
      );
    end
  endgenerate

  assign t_word = sub_word ^ {rcon_byte(cnt_reg), 24'h000000};

  logic [31:0] fwd_w0, fwd_w1, fwd_w2, fwd_w3;
  assign fwd_w0 = w0 ^ t_word;
  assign fwd_w1 = w1 ^ fwd_w0;
  assign fwd_w2 = w2 ^ fwd_w1;
  assign fwd_w3 = w3 ^ fwd_w2;

  logic [31:0] bwd_w0, bwd_w1, bwd_w2, bwd_w3;
  assign bwd_w3 = w3 ^ w2;
  assign bwd_w2 = w2 ^ w1;
  assign bwd_w1 = w1 ^ w0;
  assign bwd_w0 = w0 ^ t_word;

  always_comb begin
    state_next = state_reg;
    key_next   = key_reg;
    cnt_next   = cnt_reg;
    unique case (state_reg)
      IDLE: begin
        if (key_valid) begin
          key_next   = key_in;
          cnt_next   = 4'd1;
          state_next = EXPAND;
        end
      end
      EXPAND: begin
        key_next = {fwd_w0, fwd_w1, fwd_w2, fwd_w3};
        if (cnt_reg == LAST_ROUND) begin
          cnt_next   = LAST_ROUND;
          state_next = STREAM;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      STREAM: begin
        if (rk_ready) begin
          if (cnt_reg == 4'd0) begin
            state_next = IDLE;
          end else begin
            key_next = {bwd_w0, bwd_w1, bwd_w2, bwd_w3};
            cnt_next = cnt_reg - 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      key_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      key_reg   <= key_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign key_ready = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign rk_valid  = (state_reg == STREAM);
  assign rk_out    = key_reg;
  assign rk_idx    = (state_reg == STREAM) ? cnt_reg : 4'd0;
  assign rk_last   = (state_reg == STREAM) && (cnt_reg == 4'd0);

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Directed bench for aes_inv_key_sched using FIPS-197 and all-zero key schedules.
module tb_aes_inv_key_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_last;
  logic         busy;

  int n_asserts = 0;
  int n_fails   = 0;

  logic [127:0] fips_rk [0:10];
  logic [127:0] zero_rk [0:10];

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  aes_inv_key_sched dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_in    (key_in),
    .rk_valid  (rk_valid),
    .rk_ready  (rk_ready),
    .rk_out    (rk_out),
    .rk_idx    (rk_idx),
    .rk_last   (rk_last),
    .busy      (busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer a key, wait for acceptance, then check the 10-cycle expansion latency.
  task automatic send_key(input logic [127:0] k, input bit hold, input bit pulse,
                          output int waited);
    key_valid = 1'b1;
    key_in    = k;
    waited    = 0;
    while (!key_ready && waited < 60) begin
      step();
      waited++;
    end
    if (!key_ready) chk("key_ready_timeout", {127'd0, key_ready}, 128'd1);
    step();
    if (!hold) key_valid = 1'b0;
    chk("busy_after_hs", {127'd0, busy}, 128'd1);
    chk("key_ready_after_hs", {127'd0, key_ready}, 128'd0);
    for (int i = 1; i <= 10; i++) begin
      if (pulse && i == 3) begin
        key_valid = 1'b1;
        key_in    = ~k;
      end
      step();
      if (pulse && i == 3) begin
        chk("key_ready_in_expand", {127'd0, key_ready}, 128'd0);
        key_valid = hold;
        key_in    = k;
      end
      chk($sformatf("rk_valid_lat_%0d", i), {127'd0, rk_valid}, {127'd0, i == 10});
    end
    chk("rk_idx_first", {124'd0, rk_idx}, 128'd10);
  endtask

  // Consume rounds 10..0, optionally stalling, pulsing key_valid, or resetting at an index.
  task automatic recv_stream(input bit use_zero, input int stall_idx, input int stall_len,
                             input int pulse_idx, input int abort_idx);
    logic [127:0] exp_key;
    int           wt;
    rk_ready = 1'b1;
    for (int r = 10; r >= 0; r--) begin
      exp_key = use_zero ? zero_rk[r] : fips_rk[r];
      wt = 0;
      while (!rk_valid && wt < 20) begin
        step();
        wt++;
      end
      chk($sformatf("rk_valid_r%0d", r), {127'd0, rk_valid}, 128'd1);
      chk($sformatf("rk_idx_r%0d", r), {124'd0, rk_idx}, r[127:0]);
      chk($sformatf("rk_out_r%0d", r), rk_out, exp_key);
      chk($sformatf("rk_last_r%0d", r), {127'd0, rk_last}, {127'd0, r == 0});
      if (r == abort_idx) begin
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_rk_valid", {127'd0, rk_valid}, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_key_ready", {127'd0, key_ready}, 128'd1);
        chk("rst_rk_idx", {124'd0, rk_idx}, 128'd0);
        return;
      end
      if (r == stall_idx) begin
        rk_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          step();
          chk("stall_rk_valid", {127'd0, rk_valid}, 128'd1);
          chk("stall_rk_idx", {124'd0, rk_idx}, r[127:0]);
          chk("stall_rk_out", rk_out, exp_key);
        end
        rk_ready = 1'b1;
      end
      if (r == pulse_idx) begin
        key_valid = 1'b1;
        key_in    = 128'd0;
        chk("key_ready_in_stream", {127'd0, key_ready}, 128'd0);
      end
      step();
      if (r == pulse_idx) key_valid = 1'b0;
    end
    chk("key_ready_after_last", {127'd0, key_ready}, 128'd1);
    chk("rk_valid_after_last", {127'd0, rk_valid}, 128'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    int waited;

    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    zero_rk[0]  = 128'h00000000000000000000000000000000;
    zero_rk[1]  = 128'h62636363626363636263636362636363;
    zero_rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    zero_rk[3]  = 128'h90973450696ccffaf2f457330b0fac99;
    zero_rk[4]  = 128'hee06da7b876a1581759e42b27e91ee2b;
    zero_rk[5]  = 128'h7f2e2b88f8443e098dda7cbbf34b9290;
    zero_rk[6]  = 128'hec614b851425758c99ff09376ab49ba7;
    zero_rk[7]  = 128'h217517873550620bacaf6b3cc61bf09b;
    zero_rk[8]  = 128'h0ef903333ba9613897060a04511dfa9f;
    zero_rk[9]  = 128'hb1d4d8e28a7db9da1d7bb3de4c664941;
    zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    rst       = 1'b1;
    key_valid = 1'b0;
    key_in    = '0;
    rk_ready  = 1'b0;
    step();
    step();
    chk("reset_key_ready", {127'd0, key_ready}, 128'd1);
    chk("reset_rk_valid", {127'd0, rk_valid}, 128'd0);
    chk("reset_rk_out", rk_out, 128'd0);
    chk("reset_rk_idx", {124'd0, rk_idx}, 128'd0);
    chk("reset_rk_last", {127'd0, rk_last}, 128'd0);
    chk("reset_busy", {127'd0, busy}, 128'd0);
    rst = 1'b0;
    step();
    $display("reset checked");

    send_key(FIPS_KEY, 1'b0, 1'b0, waited);
    recv_stream(1'b0, -1, 0, -1, -1);
    $display("fips key stream done");

    send_key(128'd0, 1'b0, 1'b0, waited);
    recv_stream(1'b1, -1, 0, -1, -1);
    $display("zero key stream done");

    send_key(FIPS_KEY, 1'b0, 1'b0, waited);
    recv_stream(1'b0, 7, 3, -1, -1);
    $display("fips key stream with stall at 7 done");

    send_key(FIPS_KEY, 1'b0, 1'b1, waited);
    recv_stream(1'b0, -1, 0, 8, -1);
    $display("fips key stream with stray key_valid pulses done");

    send_key(FIPS_KEY, 1'b0, 1'b0, waited);
    recv_stream(1'b0, -1, 0, -1, 5);
    $display("reset at rk_idx 5 done");

    send_key(128'd0, 1'b0, 1'b0, waited);
    recv_stream(1'b1, -1, 0, -1, -1);
    $display("zero key stream after reset done");

    send_key(FIPS_KEY, 1'b1, 1'b0, waited);
    key_in = 128'd0;
    recv_stream(1'b0, -1, 0, -1, -1);
    send_key(128'd0, 1'b0, 1'b0, waited);
    chk("b2b_handshake_wait", waited[127:0], 128'd0);
    recv_stream(1'b1, -1, 0, -1, -1);
    $display("back-to-back keys done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
